mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Time-shares one signed multiplier among NUM_REQ requesters.
- Arbitrates round-robin, issues one operand pair per cycle into a PIPE_STAGES-deep pipeline, and returns each product with its requester ID over one ready/valid response port.
- Sits between HLS-generated loop bodies and a single mul_11s_4s-class DSP resource, replacing per-loop multiplier instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- A_W, 11, width of signed operand a
- B_W, 4, width of signed operand b
- DOUT_W, 11, width of returned signed result (low bits of full product)
- PIPE_STAGES, 2, register stages from issue to rsp_valid (>=1)
- ID_W, 2, width of rsp_id (>= clog2(NUM_REQ))

Ports:
- ap_clk  in  1  clock; all state updates on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*A_W  packed signed operand a; requester i at [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed signed operand b; requester i at [i*B_W +: B_W]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer accept
- rsp_data  out  DOUT_W  signed result
- rsp_id  out  ID_W  index of the requester that issued this result

Behaviour:
- Reset, sampled on ap_clk while ap_rst_n=0:
  - All stage valid bits clear; rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer = 0.
  - req_ready is combinational and reads 0 throughout reset.
  - Reset mid-operation discards all in-flight operations; no response is produced for them.
- Advance enable: adv = !rsp_valid | rsp_ready.
  - When adv=1, every stage shifts forward by one, bubbles included; bubbles are not collapsed.
  - When adv=0, all stages hold their contents and no request is accepted.
- Arbitration:
  - Requester i is granted when adv=1, req_valid[i]=1, and i is the first valid index found scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[i]=grant[i]; a handshake is req_valid[i] & req_ready[i].
  - On a handshake, ptr <= (i+1) mod NUM_REQ. With no handshake, ptr holds.
  - req_ready depends on req_valid and rsp_ready combinationally; requesters must not make req_valid depend on req_ready.
- Arithmetic:
  - Full product P = $signed(a) * $signed(b), width A_W+B_W.
  - Default: rsp_data = P[DOUT_W-1:0] (two's-complement wrap).
  - The product is formed combinationally at issue and captured in stage 1 together with the ID.
- Latency:
  - A handshake at cycle t gives rsp_valid=1 at cycle t+PIPE_STAGES, provided adv=1 throughout.
  - Each cycle with adv=0 adds one cycle.
- Ordering: responses leave in issue order. rsp_data and rsp_id are stable while rsp_valid & !rsp_ready.
- Throughput: one issue per cycle with rsp_ready held high.
- Requester i holding req_valid with changing operands before its handshake is a protocol violation and is not checked.

Optional Feature:
- Macro: MUL_SHARE_ARB_SAT_EN.
- Defined: rsp_data saturates P to the signed DOUT_W range [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]. Clamping is done before the stage-1 register, so latency is unchanged.
- Undefined: wrap (truncation) as described in Behaviour.

Decomposition:
- Package mul_share_pkg holds:
  - Default widths.
  - Typedef for the pipeline stage record {valid, id, data}.
  - Function rr_pick(valid_vec, ptr) returning a one-hot grant.
  - Function sat_trunc(P) implementing the wrap/saturate selection.
- Sub-module mul_share_rr_arbiter: round-robin pointer plus grant logic, taking adv as an enable.
- The top module holds the product, the stage registers and the response port.

Test Plan:
- Single request: req_valid=4'b0001, a=100, b=-3 -> rsp_valid 2 cycles after the handshake, rsp_data=-300, rsp_id=0.
- Fairness: all four valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0,1; one handshake per cycle; responses return with matching IDs in the same order.
- Backpressure: hold rsp_ready=0 for 3 cycles with the pipeline full -> req_ready=0, rsp_data/rsp_id held; release -> no loss or duplication, order preserved.
- Overflow with a=1000, b=7 (P=7000):
  - Macro undefined -> rsp_data=856.
  - MUL_SHARE_ARB_SAT_EN defined -> rsp_data=1023.
- Overflow with a=-1024, b=7 (P=-7168):
  - Macro undefined -> rsp_data=-1024.
  - Macro defined -> rsp_data=-1024.
- Reset mid-flight: two operations in the pipeline, drive ap_rst_n=0 for one cycle -> rsp_valid=0 the next cycle with no stale response afterward; ptr=0, so requester 0 wins the first post-reset contention among {0,2}.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the time-shared signed multiplier.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default widths, the pipeline stage record, rr_pick (one-hot
// round-robin grant), and sat_trunc (wrap or saturate the full product).
// Optional feature macro: MUL_SHARE_ARB_SAT_EN selects saturation in sat_trunc.
package mul_share_pkg;

   // Default configuration: 11s x 4s multiplier shared by four requesters.
   localparam int NUM_REQ_DEF     = 4;
   localparam int A_W_DEF         = 11;
   localparam int B_W_DEF         = 4;
   localparam int DOUT_W_DEF      = 11;
   localparam int PIPE_STAGES_DEF = 2;
   localparam int ID_W_DEF        = 2;

   // Upper bounds for the generic helpers. Requester count tops out at 8, so
   // a 3-bit pointer covers every legal configuration.
   localparam int MAX_REQ    = 8;
   localparam int PTR_W      = 3;
   localparam int MAX_P_W    = 64;
   localparam int MAX_DOUT_W = 32;

   // One pipeline stage record at the default widths.
   typedef struct packed {
      logic                  valid;
      logic [ID_W_DEF-1:0]   id;
      logic [DOUT_W_DEF-1:0] data;
   } stage_t;

   // One-hot grant: first set bit of valid_vec scanning ptr, ptr+1, ...
   // wrapping modulo n. Bits at or above n are ignored.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] valid_vec,
      input logic [PTR_W-1:0]   ptr,
      input int                 n
   );
      logic [MAX_REQ-1:0] grant;
      logic               found;
      int                 idx;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && !found && valid_vec[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
      return grant;
   endfunction

   // Reduce the sign-extended full product to a dout_w-bit signed result,
   // returned sign-extended to MAX_DOUT_W. Wrap keeps the low dout_w bits;
   // saturation clamps to the signed dout_w range.
   function automatic logic [MAX_DOUT_W-1:0] sat_trunc(
      input logic signed [MAX_P_W-1:0] p,
      input int                        dout_w
   );
      logic signed [MAX_P_W-1:0] r;
`ifdef MUL_SHARE_ARB_SAT_EN
      logic signed [MAX_P_W-1:0] hi;
      logic signed [MAX_P_W-1:0] lo;
      hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dout_w - 1));
      if (p > hi)      r = hi;
      else if (p < lo) r = lo;
      else             r = p;
`else
      // Shift the kept bits to the top, then arithmetic-shift back so the
      // wrapped value is sign-extended from bit dout_w-1.
      r = (p <<< (MAX_P_W - dout_w)) >>> (MAX_P_W - dout_w);
`endif
      return r[MAX_DOUT_W-1:0];
   endfunction

endpackage

// File: rtl/mul_share_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot grant.
// Latency: grant is combinational from req_valid/en; pointer updates on the next edge.
// Backpressure: en=0 forces grant to zero and freezes the pointer.
// Ports: clk, rst_n (sync active-low), en (advance enable), req_valid[NUM_REQ],
//        grant[NUM_REQ] (one-hot or zero).
module mul_share_rr_arbiter
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] grant
);

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_nxt;
   logic [MAX_REQ-1:0] vld_ext;
   logic [MAX_REQ-1:0] grant_ext;

   always_comb begin
      vld_ext                = '0;
      vld_ext[NUM_REQ-1:0]   = req_valid;
      grant_ext              = en ? rr_pick(vld_ext, ptr, NUM_REQ) : '0;
      grant                  = grant_ext[NUM_REQ-1:0];
      // Next search starts just past the winner; no winner keeps the pointer.
      ptr_nxt = ptr;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (grant_ext[i]) ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

endmodule

// File: rtl/mul_share_arb.sv
// Time-shares one signed multiplier among NUM_REQ round-robin requesters.
// Latency: PIPE_STAGES cycles from handshake to rsp_valid, plus one per stalled cycle.
// Backpressure: rsp_valid & !rsp_ready freezes every stage and blocks all grants.
// Ports: ap_clk, ap_rst_n (sync active-low); req_valid/req_ready per requester
//        with packed req_a/req_b operands; rsp_valid/rsp_ready/rsp_data/rsp_id.
// Optional feature macro: MUL_SHARE_ARB_SAT_EN (saturate instead of wrap).
module mul_share_arb
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int A_W         = A_W_DEF,
   parameter int B_W         = B_W_DEF,
   parameter int DOUT_W      = DOUT_W_DEF,
   parameter int PIPE_STAGES = PIPE_STAGES_DEF,
   parameter int ID_W        = ID_W_DEF
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DOUT_W-1:0]      rsp_data,
   output logic [ID_W-1:0]        rsp_id
);

   localparam int P_W = A_W + B_W;

   logic                     adv;
   logic                     arb_en;
   logic                     issue;
   logic [NUM_REQ-1:0]       grant;
   logic signed [A_W-1:0]    a_sel;
   logic signed [B_W-1:0]    b_sel;
   logic [ID_W-1:0]          id_sel;
   logic signed [P_W-1:0]    prod;
   logic [MAX_DOUT_W-1:0]    res_ext;

   // Stage k holds the operation issued k+1 advancing cycles ago; the last
   // stage drives the response port directly.
   logic                     stg_vld [PIPE_STAGES];
   logic [ID_W-1:0]          stg_id  [PIPE_STAGES];
   logic [DOUT_W-1:0]        stg_dat [PIPE_STAGES];

   // Whole pipeline moves as one; bubbles are shifted, never collapsed.
   assign adv    = !rsp_valid || rsp_ready;
   // Gating with reset keeps req_ready low for the whole reset period.
   assign arb_en = adv && ap_rst_n;

   mul_share_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .en        (arb_en),
      .req_valid (req_valid),
      .grant     (grant)
   );

   assign req_ready = grant;
   // A grant is only ever given to a valid requester, so any grant is a handshake.
   assign issue     = |grant;

   // Operand mux driven by the one-hot grant.
   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      id_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            a_sel  = req_a[i*A_W +: A_W];
            b_sel  = req_b[i*B_W +: B_W];
            id_sel = ID_W'(i);
         end
      end
   end

   // Full-width signed product, then wrap or clamp ahead of stage 1 so the
   // saturating build has the same latency as the wrapping one.
   assign prod    = a_sel * b_sel;
   assign res_ext = sat_trunc(MAX_P_W'(prod), DOUT_W);

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            stg_vld[k] <= 1'b0;
            stg_id[k]  <= '0;
            stg_dat[k] <= '0;
         end
      end else if (adv) begin
         stg_vld[0] <= issue;
         stg_id[0]  <= id_sel;
         stg_dat[0] <= res_ext[DOUT_W-1:0];
         for (int k = 1; k < PIPE_STAGES; k++) begin
            stg_vld[k] <= stg_vld[k-1];
            stg_id[k]  <= stg_id[k-1];
            stg_dat[k] <= stg_dat[k-1];
         end
      end
   end

   assign rsp_valid = stg_vld[PIPE_STAGES-1];
   assign rsp_id    = stg_id[PIPE_STAGES-1];
   assign rsp_data  = stg_dat[PIPE_STAGES-1];

   a_ready_onehot: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      $onehot0(req_ready));

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb with a queue-based reference model.
// Latency: n/a. Backpressure: rsp_ready driven directly by the stimulus.
module tb_mul_share_arb;

   localparam int NR = 4;
   localparam int AW = 11;
   localparam int BW = 4;
   localparam int DW = 11;
   localparam int PS = 2;
   localparam int IW = 2;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_a;
   logic [NR*BW-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [DW-1:0]    rsp_data;
   logic [IW-1:0]    rsp_id;

   int op_a [NR];
   int op_b [NR];

   int checks = 0;
   int errors = 0;

   mul_share_arb #(
      .NUM_REQ(NR), .A_W(AW), .B_W(BW), .DOUT_W(DW), .PIPE_STAGES(PS), .ID_W(IW)
   ) dut (
      .ap_clk    (clk),
      .ap_rst_n  (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NR; i++) begin
         req_a[i*AW +: AW] = AW'(op_a[i]);
         req_b[i*BW +: BW] = BW'(op_b[i]);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the definition: signed product,
   // then either clamp to the 11-bit range or keep its low 11 bits.
   function automatic int exp_res(input int a, input int b);
      int p;
      logic signed [DW-1:0] w;
      p = a * b;
`ifdef MUL_SHARE_ARB_SAT_EN
      if (p > 1023)  return 1023;
      if (p < -1024) return -1024;
`endif
      w = DW'(p);
      return int'(w);
   endfunction

   // Model: each issued operation becomes visible after PS advancing edges
   // (the issuing edge counts as the first). cnt = advancing edges still needed.
   typedef struct {
      mul_share_pkg::stage_t rec;
      int                    cnt;
   } exp_t;

   exp_t q[$];
   int   mptr = 0;

   initial begin : compare
      logic          exp_vld;
      logic          adv;
      logic          found;
      logic [NR-1:0] exp_rdy;
      int            win;
      exp_t          e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_vld = (q.size() > 0) && (q[0].cnt == 0);
         chk("rsp_valid", int'(rsp_valid), int'(exp_vld));
         if (exp_vld) begin
            chk("rsp_data", int'($signed(rsp_data)), int'($signed(q[0].rec.data)));
            chk("rsp_id", int'(rsp_id), int'(q[0].rec.id));
         end
         adv     = !exp_vld || rsp_ready;
         exp_rdy = '0;
         found   = 1'b0;
         win     = 0;
         if (rst_n && adv) begin
            for (int k = 0; k < NR; k++) begin
               if (!found && req_valid[(mptr + k) % NR]) begin
                  win          = (mptr + k) % NR;
                  exp_rdy[win] = 1'b1;
                  found        = 1'b1;
               end
            end
         end
         chk("req_ready", int'(req_ready), int'(exp_rdy));
         // Advance the model over the coming rising edge.
         if (!rst_n) begin
            q.delete();
            mptr = 0;
         end else if (adv) begin
            if (exp_vld) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
               e     = q[i];
               e.cnt = e.cnt - 1;
               q[i]  = e;
            end
            if (found) begin
               e.rec.valid = 1'b1;
               e.rec.id    = IW'(win);
               e.rec.data  = DW'(exp_res(op_a[win], op_b[win]));
               e.cnt       = PS - 1;
               q.push_back(e);
               mptr = (win + 1) % NR;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request from requester idx; checks the literal result PS cycles
   // after its handshake.
   task automatic single_op(input int idx, input int a, input int b, input int exp);
      logic got;
      op_a[idx] = a;
      op_b[idx] = b;
      req_valid = '0;
      req_valid[idx] = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = req_ready[idx];
         if (!got) tick();
      end
      chk("single_handshake", int'(got), 1);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("single_lat_early", int'(rsp_valid), 0);
      @(negedge clk);
      chk("single_lat_valid", int'(rsp_valid), 1);
      chk("single_data", int'($signed(rsp_data)), exp);
      chk("single_id", int'(rsp_id), idx);
      tick();
      tick();
   endtask

   initial begin : stim
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         op_a[i] = 0;
         op_b[i] = 0;
      end
      tick();
      tick();
      @(negedge clk);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_rsp_data", int'(rsp_data), 0);
      chk("reset_rsp_id", int'(rsp_id), 0);
      req_valid = 4'b1111;
      #1;
      chk("reset_req_ready", int'(req_ready), 0);
      tick();
      req_valid = '0;
      rst_n = 1'b1;
      tick();

      // Pin the reference arithmetic.
      chk("model_small", exp_res(100, -3), -300);
`ifdef MUL_SHARE_ARB_SAT_EN
      chk("model_pos_ovf", exp_res(1000, 7), 1023);
`else
      chk("model_pos_ovf", exp_res(1000, 7), 856);
`endif
      chk("model_neg_ovf", exp_res(-1024, 7), -1024);

      // Single request.
      single_op(0, 100, -3, -300);

      // Fresh pointer, then fairness with all four requesters valid.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      op_a[0] = 123;  op_b[0] = 2;
      op_a[1] = -45;  op_b[1] = 3;
      op_a[2] = 300;  op_b[2] = -4;
      op_a[3] = -512; op_b[3] = 5;
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("fair_grant", int'(req_ready), 1 << (k % 4));
         tick();
      end

      // Backpressure with the pipeline full.
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_req_ready", int'(req_ready), 0);
         chk("bp_rsp_valid", int'(rsp_valid), 1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      tick();
      req_valid = '0;
      for (int k = 0; k < 4; k++) tick();

      // Overflow cases.
`ifdef MUL_SHARE_ARB_SAT_EN
      single_op(3, 1000, 7, 1023);
      single_op(1, -1000, 7, -1024);
`else
      single_op(3, 1000, 7, 856);
      single_op(1, -1000, 7, -856);
`endif
      single_op(2, -1024, 7, -1024);

      // Reset with two operations in flight.
      op_a[0] = 5;  op_b[0] = 3;
      req_valid = 4'b0001;
      tick();
      op_a[1] = 6;  op_b[1] = -2;
      req_valid = 4'b0010;
      tick();
      op_a[2] = 7;  op_b[2] = 7;
      req_valid = 4'b0101;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", int'(req_ready), 0);
      chk("midrst_inflight", int'(rsp_valid), 1);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_rsp_valid", int'(rsp_valid), 0);
      chk("postrst_grant", int'(req_ready), 1);
      tick();
      req_valid = '0;
      for (int k = 0; k < 6; k++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
